// File: rtl/pic_call_stack.sv
// Parametrised return-address stack with occupancy, status and sticky error flags.
// Define PIC_STACK_WRAP_EN for legacy circular (wrapping) behaviour; default saturates.
module pic_call_stack #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic                       Push,
    input  logic                       Pop,
    input  logic [WIDTH-1:0]           Push_Data,
    input  logic                       Clear_Errors,
    output logic [WIDTH-1:0]           Top,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Empty,
    output logic                       Full,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
`ifdef PIC_STACK_WRAP_EN
    localparam int unsigned PW = AW;
`else
    localparam int unsigned PW = AW + 1;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, unf_q;
    logic             ovf_set, unf_set;
    logic             wr_en;
    logic [AW-1:0]    wr_idx, push_idx, top_idx;

    assign push_idx = AW'(ptr_q);
    assign top_idx  = AW'(ptr_q - PW'(1));

    assign Count     = cnt_q;
    assign Empty     = (cnt_q == '0);
    assign Full      = (cnt_q == CW'(DEPTH));
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

`ifdef PIC_STACK_WRAP_EN
    // Legacy behaviour: the slot below the pointer is visible even when empty.
    assign Top = mem_q[top_idx];
`else
    assign Top = Empty ? '0 : mem_q[top_idx];
`endif

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = push_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({Push, Pop})
            2'b10: begin
                if (!Full) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PW'(1);
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    ovf_set = 1'b1;
`ifdef PIC_STACK_WRAP_EN
                    // Overwrites the oldest entry; Count stays at DEPTH.
                    wr_en = 1'b1;
                    ptr_d = ptr_q + PW'(1);
`endif
                end
            end
            2'b01: begin
                if (!Empty) begin
                    ptr_d = ptr_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    unf_set = 1'b1;
`ifdef PIC_STACK_WRAP_EN
                    ptr_d = ptr_q - PW'(1);
`endif
                end
            end
            2'b11: begin
                if (Empty) begin
                    // Nothing to replace: behaves as a plain push, pop half flagged.
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                    cnt_d   = cnt_q + CW'(1);
                    unf_set = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            mem_q <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx] <= Push_Data;
            end
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            // A new error in the same cycle as Clear_Errors keeps the flag set.
            ovf_q <= ovf_set | (ovf_q & ~Clear_Errors);
            unf_q <= unf_set | (unf_q & ~Clear_Errors);
        end
    end

endmodule

// File: tb/tb_pic_call_stack.sv
// Randomised and directed bench for pic_call_stack against a queue-based stack model.
// Compile with PIC_STACK_WRAP_EN defined to exercise the circular build.
module tb_pic_call_stack;

    localparam int unsigned W   = 13;
    localparam int unsigned D   = 8;
    localparam int unsigned CW  = $clog2(D+1);
    localparam int unsigned W2  = 16;
    localparam int unsigned D2  = 16;
    localparam int unsigned CW2 = $clog2(D2+1);

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic          Push = 1'b0, Pop = 1'b0, Clear_Errors = 1'b0;
    logic [W-1:0]  Push_Data = '0;
    logic [W-1:0]  Top;
    logic [CW-1:0] Count;
    logic          Empty, Full, Overflow, Underflow;

    logic           b_push = 1'b0, b_pop = 1'b0;
    logic [W2-1:0]  b_data = '0;
    logic [W2-1:0]  b_top;
    logic [CW2-1:0] b_count;
    logic           b_empty, b_full, b_ovf, b_unf;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [W-1:0] m_stk[$];
    bit           m_ovf = 1'b0, m_unf = 1'b0;

    always #5 Clk = ~Clk;

    pic_call_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .Clk(Clk), .nReset(nReset), .Push(Push), .Pop(Pop), .Push_Data(Push_Data),
        .Clear_Errors(Clear_Errors), .Top(Top), .Count(Count), .Empty(Empty),
        .Full(Full), .Overflow(Overflow), .Underflow(Underflow)
    );

    pic_call_stack #(.WIDTH(W2), .DEPTH(D2)) dut16 (
        .Clk(Clk), .nReset(nReset), .Push(b_push), .Pop(b_pop), .Push_Data(b_data),
        .Clear_Errors(1'b0), .Top(b_top), .Count(b_count), .Empty(b_empty),
        .Full(b_full), .Overflow(b_ovf), .Underflow(b_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_op(input bit push, input bit pop, input logic [W-1:0] d, input bit clr);
        bit ovs, uns;
        ovs = 1'b0;
        uns = 1'b0;
        if (push && !pop) begin
            if (m_stk.size() < D) m_stk.push_back(d);
            else begin
                ovs = 1'b1;
`ifdef PIC_STACK_WRAP_EN
                m_stk.delete(0);
                m_stk.push_back(d);
`endif
            end
        end else if (!push && pop) begin
            if (m_stk.size() > 0) m_stk.delete(m_stk.size() - 1);
            else uns = 1'b1;
        end else if (push && pop) begin
            if (m_stk.size() == 0) begin
                m_stk.push_back(d);
                uns = 1'b1;
            end else begin
                m_stk[m_stk.size() - 1] = d;
            end
        end
        m_ovf = ovs | (m_ovf & !clr);
        m_unf = uns | (m_unf & !clr);
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 32'(Count), m_stk.size());
        check({tag, ".empty"}, 32'(Empty), 32'(m_stk.size() == 0));
        check({tag, ".full"},  32'(Full),  32'(m_stk.size() == D));
        check({tag, ".ovf"},   32'(Overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(Underflow), 32'(m_unf));
        if (m_stk.size() > 0) check({tag, ".top"}, 32'(Top), 32'(m_stk[m_stk.size() - 1]));
`ifndef PIC_STACK_WRAP_EN
        else check({tag, ".top0"}, 32'(Top), 32'h0);
`endif
    endtask

    task automatic step(input bit push, input bit pop, input logic [W-1:0] d, input bit clr,
                        input string tag);
        @(negedge Clk);
        Push = push; Pop = pop; Push_Data = d; Clear_Errors = clr;
        @(posedge Clk);
        model_op(push, pop, d, clr);
        #1;
        compare_all(tag);
        Push = 1'b0; Pop = 1'b0; Clear_Errors = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        compare_all("rst");
        @(negedge Clk);
        nReset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned bias [6];
        bias = '{80, 20, 60, 50, 90, 10};

        #3;
        compare_all("por");
        @(negedge Clk);
        nReset = 1'b1;

        // Scenario 1: fill then drain.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(32'h100 + i), 1'b0, "s1_push");
        check("s1_top_full", 32'(Top), 32'h107);
        check("s1_full", 32'(Full), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, "s1_pop");
        check("s1_empty", 32'(Empty), 32'h1);

        // Scenario 2: replace.
        do_reset();
        step(1'b1, 1'b0, W'(32'hABC), 1'b0, "s2_push");
        step(1'b1, 1'b1, W'(32'h1234), 1'b0, "s2_repl");
        check("s2_top", 32'(Top), 32'h1234);
        check("s2_count", 32'(Count), 32'h1);
        step(1'b0, 1'b1, '0, 1'b0, "s2_pop");
        check("s2_unf", 32'(Underflow), 32'h0);

`ifndef PIC_STACK_WRAP_EN
        // Scenario 3: saturating boundaries.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'(32'h100 + i), 1'b0, "s3_fill");
        step(1'b1, 1'b0, W'(32'h1FFF), 1'b0, "s3_ovf");
        check("s3_top", 32'(Top), 32'h107);
        check("s3_ovf_flag", 32'(Overflow), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, "s3_drain");
        step(1'b0, 1'b1, '0, 1'b0, "s3_unf");
        check("s3_unf_flag", 32'(Underflow), 32'h1);
        step(1'b1, 1'b1, W'(32'h55), 1'b0, "s3_pp_empty");
        check("s3_pp_count", 32'(Count), 32'h1);
        step(1'b0, 1'b0, '0, 1'b1, "s3_clr");
        check("s3_clr_ovf", 32'(Overflow), 32'h0);
        check("s3_clr_unf", 32'(Underflow), 32'h0);
`else
        // Scenario 4: circular overwrite.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, W'(i), 1'b0, "s4_push");
        check("s4_top", 32'(Top), 32'h9);
        check("s4_ovf_flag", 32'(Overflow), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, 1'b0, "s4_pop");
        check("s4_last_top", 32'(Top), 32'h9);
        step(1'b0, 1'b1, '0, 1'b0, "s4_unf");
        check("s4_unf_flag", 32'(Underflow), 32'h1);
`endif

        // Scenario 5: error set beats clear.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, "s5_fill");
        step(1'b1, 1'b0, W'(32'h77), 1'b1, "s5_ovf_clr");
        check("s5_ovf_flag", 32'(Overflow), 32'h1);
        step(1'b1, 1'b1, W'(32'h99), 1'b0, "s5_repl_full");

        // Scenario 6: asynchronous reset between edges.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(32'h200 + i), 1'b0, "s6_push");
        #2;
        nReset = 1'b0;
        #1;
        check("s6_count", 32'(Count), 32'h0);
        check("s6_empty", 32'(Empty), 32'h1);
        check("s6_top", 32'(Top), 32'h0);
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        step(1'b1, 1'b0, W'(32'h42), 1'b0, "s6_after");
        check("s6_after_top", 32'(Top), 32'h42);

        // Scenario 7: 16-deep, 16-bit instance.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            b_push = 1'b1;
            b_data = W2'(32'h100 + i);
            @(posedge Clk);
            #1;
            check("s7_count", 32'(b_count), 32'(i + 1));
            check("s7_full", 32'(b_full), 32'(i == 15));
            check("s7_top", 32'(b_top), 32'h100 + 32'(i));
        end
        @(negedge Clk);
        b_push = 1'b0;
        b_pop  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge Clk);
            #1;
            check("s7_pop_count", 32'(b_count), 32'(15 - i));
            if (i < 15) check("s7_pop_top", 32'(b_top), 32'h100 + 32'(14 - i));
            else        check("s7_empty", 32'(b_empty), 32'h1);
        end
        @(negedge Clk);
        b_pop = 1'b0;
        check("s7_flags", 32'({b_ovf, b_unf}), 32'h0);

        // Randomised phases with shifting push bias to hit both boundaries.
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 100; n++) begin
                bit pu, po, cl;
                pu = ($urandom_range(0, 99) < bias[ph]);
                po = ($urandom_range(0, 99) < (100 - bias[ph]));
                cl = ($urandom_range(0, 7) == 0);
                step(pu, po, W'($urandom), cl, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
